// File: rtl/mux_rr_reg.sv
// mux_rr_reg: registered NCH-channel, WIDTH-bit multiplexer with valid/ready
// handshakes. Channel selection is either fixed (external sel) or round-robin.
// One output register stage (data, valid), no skid buffer.
// Optional feature: define MUX_GRANT_ID_EN to add the registered grant_id
// output, which reports the channel index of the word held in out_data.
module mux_rr_reg #(
  parameter int WIDTH = 5,
  parameter int NCH   = 2,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_GRANT_ID_EN
  ,
  output logic [SELW-1:0]      grant_id
`endif
);

  localparam logic [SELW:0]   NCH_S   = (SELW+1)'(NCH);
  localparam logic [SELW+1:0] NCH_W   = (SELW+2)'(NCH);
  localparam logic [SELW-1:0] PTR_RST = SELW'(NCH - 1);

  logic [SELW-1:0]  ptr_reg;
  logic             load_en;
  logic [2*NCH-1:0] valid_dbl;
  logic [2*NCH-1:0] valid_rot;
  logic [SELW:0]    start;
  logic             rr_found;
  logic [SELW-1:0]  rr_offset;
  logic [SELW+1:0]  rr_sum;
  logic [SELW-1:0]  rr_grant;
  logic [SELW-1:0]  cand;
  logic             cand_ok;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  // The register accepts a word when empty or being drained this cycle.
  assign load_en = ~out_valid | out_ready;

  // Rotate requests so that channel ptr+1 lands on bit 0; start may equal
  // NCH, which the doubled vector turns into a zero rotation.
  assign start     = {1'b0, ptr_reg} + 1'b1;
  assign valid_dbl = {in_valid, in_valid};
  assign valid_rot = valid_dbl >> start;

  // Find the first requester in rotated order (lowest set bit wins).
  always_comb begin
    rr_found  = 1'b0;
    rr_offset = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (valid_rot[j]) begin
        rr_found  = 1'b1;
        rr_offset = SELW'(j);
      end
    end
  end

  // Map the rotated offset back to an absolute channel index (mod NCH).
  assign rr_sum   = {1'b0, start} + {2'b00, rr_offset};
  assign rr_grant = (rr_sum >= NCH_W) ? SELW'(rr_sum - NCH_W) : SELW'(rr_sum);

  // Pick the candidate channel for this cycle from the current mode.
  always_comb begin
    cand    = sel;
    cand_ok = ({1'b0, sel} < NCH_S);
    if (mode) begin
      cand    = rr_grant;
      cand_ok = rr_found;
    end
  end

  // Only the candidate channel sees ready, and only when the register can load.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign in_ready[gi] = rst_n & load_en & cand_ok & (cand == SELW'(gi));
    end
  endgenerate

  assign xfer = |(in_ready & in_valid);

  // Data mux driven by the candidate index; unused when no transfer occurs.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cand == SELW'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output register: load on transfer, drain when consumed with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: moves to the granted channel, only in round-robin mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= PTR_RST;
    end else if (xfer && mode) begin
      ptr_reg <= cand;
    end
  end

`ifdef MUX_GRANT_ID_EN
  // Channel tag registered alongside out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id <= '0;
    end else if (xfer) begin
      grant_id <= cand;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_reg.sv
// tb_mux_rr_reg: randomized and directed bench for mux_rr_reg. Two instances
// (NCH=2 and NCH=3, WIDTH=5) are checked against a behavioural model that
// tracks the expected output word, the round-robin pointer and producer state.
module tb_mux_rr_reg;
  localparam int W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           mode;
  logic           out_ready;
  logic [0:0]     a_sel;
  logic [1:0]     b_sel;
  logic [2*W-1:0] a_in_data;
  logic [1:0]     a_in_valid, a_in_ready;
  logic [W-1:0]   a_out_data;
  logic           a_out_valid;
  logic [3*W-1:0] b_in_data;
  logic [2:0]     b_in_valid, b_in_ready;
  logic [W-1:0]   b_out_data;
  logic           b_out_valid;
`ifdef MUX_GRANT_ID_EN
  logic [0:0]     a_gid;
  logic [1:0]     b_gid;
`endif

  mux_rr_reg #(.WIDTH(W), .NCH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(a_sel),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready)
`ifdef MUX_GRANT_ID_EN
    , .grant_id(a_gid)
`endif
  );

  mux_rr_reg #(.WIDTH(W), .NCH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready)
`ifdef MUX_GRANT_ID_EN
    , .grant_id(b_gid)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model and producer state, index 0 = u_a, 1 = u_b.
  int           nch [2] = '{2, 3};
  int           m_ptr [2];
  logic         m_ov [2];
  logic [W-1:0] m_od [2];
  int           m_gid [2];
  logic [2:0]   vld [2];
  logic [W-1:0] dat [2][3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = nch[d] - 1;
      m_ov[d]  = 1'b0;
      m_od[d]  = '0;
      m_gid[d] = 0;
    end
  endtask

  // Expected ready mask from the selection rules, in plain arithmetic.
  function automatic logic [2:0] exp_ready(input int n, input logic md, input int s,
                                           input logic [2:0] v, input int p,
                                           input logic ov, input logic ordy);
    logic [2:0] r;
    r = '0;
    if (ov && !ordy) return r;
    if (!md) begin
      if (s < n) r = 3'(1 << s);
    end else begin
      for (int i = 1; i <= n; i++) begin
        int k;
        k = (p + i) % n;
        if (v[k]) begin
          r = 3'(1 << k);
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic apply();
    for (int k = 0; k < 2; k++) a_in_data[k*W +: W] = dat[0][k];
    for (int k = 0; k < 3; k++) b_in_data[k*W +: W] = dat[1][k];
    a_in_valid = vld[0][1:0];
    b_in_valid = vld[1];
  endtask

  task automatic refill_all();
    vld[0] = 3'b011;
    vld[1] = 3'b111;
  endtask

  // One clock cycle: called at a falling edge with inputs prepared.
  task automatic step();
    logic [2:0] er [2];
    logic [2:0] xf;
    int s [2];
    s[0] = int'(a_sel);
    s[1] = int'(b_sel);
    apply();
    #1;
    for (int d = 0; d < 2; d++)
      er[d] = exp_ready(nch[d], mode, s[d], vld[d], m_ptr[d], m_ov[d], out_ready);
    check("a_in_ready", 32'(a_in_ready), 32'(er[0][1:0]));
    check("b_in_ready", 32'(b_in_ready), 32'(er[1]));
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      xf = er[d] & vld[d];
      if (xf != 3'b000) begin
        int k;
        k = xf[0] ? 0 : (xf[1] ? 1 : 2);
        m_od[d]  = dat[d][k];
        m_ov[d]  = 1'b1;
        m_gid[d] = k;
        if (mode) m_ptr[d] = k;
        vld[d][k] = 1'b0;
      end else if (out_ready) begin
        m_ov[d] = 1'b0;
      end
    end
    #1;
    check("a_out_valid", 32'(a_out_valid), 32'(m_ov[0]));
    check("a_out_data",  32'(a_out_data),  32'(m_od[0]));
    check("b_out_valid", 32'(b_out_valid), 32'(m_ov[1]));
    check("b_out_data",  32'(b_out_data),  32'(m_od[1]));
`ifdef MUX_GRANT_ID_EN
    check("a_grant_id", 32'(a_gid), 32'(m_gid[0]));
    check("b_grant_id", 32'(b_gid), 32'(m_gid[1]));
`endif
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; out_ready = 1'b0; a_sel = '0; b_sel = '0;
    dat[0] = '{5'd10, 5'd20, 5'd0};
    dat[1] = '{5'd1, 5'd2, 5'd3};
    refill_all();
    model_reset();
    apply();

    // Reset: all valid, nothing ready, output empty and zero.
    #2;
    check("rst_a_in_ready", 32'(a_in_ready), 0);
    check("rst_b_in_ready", 32'(b_in_ready), 0);
    check("rst_a_out_valid", 32'(a_out_valid), 0);
    check("rst_a_out_data", 32'(a_out_data), 0);
    check("rst_b_out_valid", 32'(b_out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First round-robin grant after reset goes to channel 0.
    mode = 1'b1; out_ready = 1'b1;
    step();
    check("rst_first_grant_a", 32'(a_out_data), 10);
    check("rst_first_grant_b", 32'(b_out_data), 1);

    // Fixed select.
    mode = 1'b0; a_sel = 1'b0; refill_all();
    step();
    check("fix_sel0", 32'(a_out_data), 10);
    a_sel = 1'b1; refill_all();
    step();
    check("fix_sel1", 32'(a_out_data), 20);

    // Round-robin fairness: pointer is at 0, so grants alternate 1,0,1,0.
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      refill_all();
      step();
      check("rr_alt", 32'(a_out_data), (i % 2 == 0) ? 20 : 10);
    end

    // Backpressure: word frozen, nothing ready, then same-cycle reload.
    out_ready = 1'b0; refill_all();
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_in_ready", 32'(a_in_ready), 0);
      check("bp_valid", 32'(a_out_valid), 1);
      check("bp_hold", 32'(a_out_data), 10);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(a_out_valid), 1);
    check("bp_release_data", 32'(a_out_data), 20);

    // Out-of-range select on the 3-channel instance.
    mode = 1'b0; a_sel = 1'b0; b_sel = 2'd3; refill_all();
    step();
    check("oor_ready", 32'(b_in_ready), 0);
    check("oor_drain", 32'(b_out_valid), 0);
    step();
    check("oor_stay", 32'(b_out_valid), 0);

    // Wrap and mode switch on u_b (pointer at 2): only ch0 and ch2 request.
    mode = 1'b1; vld[1] = 3'b101;
    step();
    check("wrap_g0", 32'(b_out_data), 1);
    vld[1] = 3'b101;
    step();
    check("wrap_g2", 32'(b_out_data), 3);
    vld[1] = 3'b101;
    step();
    check("wrap_g0_again", 32'(b_out_data), 1);
    mode = 1'b0; b_sel = 2'd2; vld[1] = 3'b100;
    step();
    check("switch_fixed_ch2", 32'(b_out_data), 3);
    mode = 1'b1; vld[1] = 3'b101;
    step();
    check("ptr_kept_0", 32'(b_out_data), 3);

    // Reset asserted mid-cycle while a transfer is pending.
    mode = 1'b1; out_ready = 1'b1; refill_all(); apply();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_a_ready", 32'(a_in_ready), 0);
    check("midrst_a_valid", 32'(a_out_valid), 0);
    check("midrst_a_data", 32'(a_out_data), 0);
    check("midrst_b_valid", 32'(b_out_valid), 0);
    model_reset();
    @(posedge clk);
    #1;
    check("midrst_hold_valid", 32'(a_out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    refill_all();
    step();
    check("midrst_first_grant", 32'(a_out_data), 10);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      a_sel     = 1'($urandom_range(0, 1));
      b_sel     = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < nch[d]; k++) begin
          if (!vld[d][k] && ($urandom_range(0, 1) == 1)) begin
            vld[d][k] = 1'b1;
            dat[d][k] = W'($urandom);
          end
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
